// File: rtl/updi_tx_sequencer_pkg.sv
// Shared types and frame constants for the UPDI transmit sequencer.
package updi_pkg;

  // Transmit sequencer states, in the order a byte frame walks through them.
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    POP    = 4'd1,
    LOAD   = 4'd2,
    START  = 4'd3,
    DATA   = 4'd4,
    PARITY = 4'd5,
    STOP   = 4'd6,
    GUARD  = 4'd7,
    BREAK  = 4'd8,
    BRK_HI = 4'd9
  } tx_state_t;

  localparam int UPDI_DATA_BITS = 8;
  localparam int UPDI_STOP_BITS = 2;
  localparam int BRK_HI_BITS    = 2;

  // Running even-parity accumulation: fold one transmitted data bit in.
  function automatic logic parity_step(input logic acc, input logic data_bit);
    return acc ^ data_bit;
  endfunction

endpackage

// File: rtl/updi_tx_sequencer_baud_tick.sv
// Bit-time divider: tick marks the last clk cycle of each CLK_DIV-cycle bit
// time. restart forces the next cycle to be the first cycle of a bit time,
// so every state entry begins a fresh, full-length bit.
module baud_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next divider value: wrap at the end of a bit time or on restart.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/updi_tx_sequencer.sv
// UPDI transmit sequencer: pops bytes from the TX FIFO and sends each as a
// 12-bit UART frame (start, 8 data LSB first, even parity, 2 stop), followed
// by optional idle guard bits. Also sends BREAK sequences on request; a
// pending break always wins over queued FIFO data at the next IDLE.
module updi_tx_sequencer
  import updi_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int GUARD_BITS = 2,
  parameter int BREAK_BITS = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic       break_req,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       break_done
);

  // Bit counter is shared by every multi-bit state; 16 bits covers any
  // practical BREAK length.
  localparam int BCW = 16;
  localparam logic [BCW-1:0] DATA_LAST   = BCW'(UPDI_DATA_BITS - 1);
  localparam logic [BCW-1:0] STOP_LAST   = BCW'(UPDI_STOP_BITS - 1);
  localparam logic [BCW-1:0] BRK_HI_LAST = BCW'(BRK_HI_BITS - 1);
  localparam logic [BCW-1:0] BREAK_LAST  = BCW'((BREAK_BITS > 0) ? BREAK_BITS - 1 : 0);
  localparam logic [BCW-1:0] GUARD_LAST  = BCW'((GUARD_BITS > 0) ? GUARD_BITS - 1 : 0);
  localparam logic           HAS_GUARD   = (GUARD_BITS > 0);

  tx_state_t      state_q, state_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           brk_pend_q, brk_pend_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           par_q, par_d;
  logic           tick;
  logic           restart;

  // Any state change restarts the bit-time divider.
  assign restart = (state_d != state_q);

  baud_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .tick    (tick)
  );

  // Next-state logic, bit counting, shift/parity updates and break latching.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    brk_pend_d = brk_pend_q | break_req;

    unique case (state_q)
      IDLE: begin
        // A break requested this very cycle still outranks FIFO data.
        if (brk_pend_q || break_req) begin
          state_d    = BREAK;
          brk_pend_d = 1'b0;
          bit_cnt_d  = '0;
        end else if (enable && !fifo_empty) begin
          state_d = POP;
        end
      end

      POP: begin
        state_d = LOAD;
      end

      LOAD: begin
        shreg_d   = fifo_data;
        par_d     = 1'b0;
        bit_cnt_d = '0;
        state_d   = START;
      end

      START: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end

      DATA: begin
        if (tick) begin
          par_d   = parity_step(par_q, shreg_q[0]);
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      PARITY: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = STOP;
        end
      end

      STOP: begin
        if (tick) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = HAS_GUARD ? GUARD : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      GUARD: begin
        if (tick) begin
          if (bit_cnt_q == GUARD_LAST) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      BREAK: begin
        if (tick) begin
          if (bit_cnt_q == BREAK_LAST) begin
            bit_cnt_d = '0;
            state_d   = BRK_HI;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      BRK_HI: begin
        if (tick) begin
          if (bit_cnt_q == BRK_HI_LAST) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Outputs decoded purely from registered state, counters and shifter.
  always_comb begin
    tx         = 1'b1;
    fifo_rd_en = 1'b0;
    busy       = (state_q != IDLE);
    frame_done = 1'b0;
    break_done = 1'b0;

    unique case (state_q)
      POP:     fifo_rd_en = 1'b1;
      START:   tx = 1'b0;
      DATA:    tx = shreg_q[0];
      PARITY:  tx = par_q;
      STOP:    frame_done = tick && (bit_cnt_q == STOP_LAST);
      BREAK:   tx = 1'b0;
      BRK_HI:  break_done = tick && (bit_cnt_q == BRK_HI_LAST);
      default: tx = 1'b1;
    endcase
  end

  // Control registers: state, bit counter, pending break.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      brk_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      brk_pend_q <= brk_pend_d;
    end
  end

  // Datapath registers: only read after LOAD has written them, so no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    par_q   <= par_d;
  end

endmodule

// File: tb/tb_updi_tx_sequencer.sv
// Directed bench for updi_tx_sequencer: table of byte frames plus hand-built
// sequences for back-to-back frames, break priority, break during a frame,
// enable drop, mid-frame reset and a no-guard instance.
module tb_updi_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       break_req;
  logic       brk_b;

  // DUT A: CLK_DIV=4, GUARD_BITS=2, BREAK_BITS=24
  logic [7:0] fifo_data_a;
  logic       fifo_empty_a;
  logic       fifo_rd_en_a;
  logic       tx, busy, frame_done, break_done;

  // DUT B: CLK_DIV=4, GUARD_BITS=0
  logic [7:0] fifo_data_b;
  logic       fifo_empty_b;
  logic       fifo_rd_en_b;
  logic       tx_b, busy_b, frame_done_b, break_done_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] mem_a [0:255];
  logic [7:0] mem_b [0:255];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  int bad_rd = 0;

  always #5 clk = ~clk;

  updi_tx_sequencer #(.CLK_DIV(4), .GUARD_BITS(2), .BREAK_BITS(24)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_data(fifo_data_a), .fifo_empty(fifo_empty_a), .fifo_rd_en(fifo_rd_en_a),
    .break_req(break_req), .tx(tx), .busy(busy),
    .frame_done(frame_done), .break_done(break_done)
  );

  updi_tx_sequencer #(.CLK_DIV(4), .GUARD_BITS(0), .BREAK_BITS(24)) dut_ng (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_data(fifo_data_b), .fifo_empty(fifo_empty_b), .fifo_rd_en(fifo_rd_en_b),
    .break_req(brk_b), .tx(tx_b), .busy(busy_b),
    .frame_done(frame_done_b), .break_done(break_done_b)
  );

  // FIFO models: data appears the cycle after the read strobe.
  assign fifo_empty_a = (wr_a == rd_a);
  assign fifo_empty_b = (wr_b == rd_b);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en_a) begin
      if (fifo_empty_a) bad_rd <= bad_rd + 1;
      fifo_data_a <= mem_a[rd_a % 256];
      rd_a <= rd_a + 1;
    end
    if (fifo_rd_en_b) begin
      if (fifo_empty_b) bad_rd <= bad_rd + 1;
      fifo_data_b <= mem_b[rd_b % 256];
      rd_b <= rd_b + 1;
    end
  end

  typedef struct {
    logic [7:0]  data;
    logic [0:11] pat;   // tx level per bit time, first bit time on the left
  } vec_t;

  vec_t vec [6];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_a(input logic [7:0] b);
    mem_a[wr_a % 256] = b;
    wr_a++;
  endtask

  task automatic push_b(input logic [7:0] b);
    mem_b[wr_b % 256] = b;
    wr_b++;
  endtask

  // Advance negedges until tx is low, at most limit cycles.
  task automatic wait_start(input int limit, output int n);
    n = 0;
    while (tx !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_timeout"}, int'(n < 300), 1);
    skip(2);
  endtask

  // Entered at the negedge of the first START cycle; walks the 48-cycle frame.
  task automatic check_frame(input string nm, input logic [0:11] pat,
                             input int brk_at, input int en_off_at);
    logic [3:0] s [12];
    int fd_pos, fd_cnt;
    fd_pos = -1;
    fd_cnt = 0;
    for (int k = 0; k < 48; k++) begin
      if (k > 0) @(negedge clk);
      s[k / 4][k % 4] = tx;
      if (frame_done) begin
        fd_cnt++;
        fd_pos = k;
      end
      if (k == brk_at) break_req = 1'b1;
      if (k == brk_at + 1) break_req = 1'b0;
      if (k == en_off_at) enable = 1'b0;
    end
    for (int b = 0; b < 12; b++)
      chk($sformatf("%s_bit%0d", nm, b), int'(s[b]), pat[b] ? 15 : 0);
    chk({nm, "_frame_done_pos"}, fd_pos, 47);
    chk({nm, "_frame_done_cnt"}, fd_cnt, 1);
  endtask

  initial begin
    int n, h, l, s1, s2, rd0, bd_pos, bd_rd, bd_cnt, busy_idle, tx0_cnt, busy_cnt;

    vec[0] = '{8'h55, 12'b010101010011};
    vec[1] = '{8'h01, 12'b010000000111};
    vec[2] = '{8'h03, 12'b011000000011};
    vec[3] = '{8'hA5, 12'b010100101011};
    vec[4] = '{8'hFF, 12'b011111111011};
    vec[5] = '{8'h80, 12'b000000001111};

    rst_n = 1'b0; enable = 1'b0; break_req = 1'b0; brk_b = 1'b0;
    fifo_data_a = 8'h00; fifo_data_b = 8'h00;
    skip(3);

    // Reset state
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en_a, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_break_done", break_done, 0);
    chk("rst_b_tx", tx_b, 1);
    rst_n = 1'b1;
    enable = 1'b1;
    skip(3);

    // Table of single frames: latency, bit pattern, frame_done, guard tail
    for (int i = 0; i < 6; i++) begin
      rd0 = rd_a;
      push_a(vec[i].data);
      wait_start(20, n);
      chk($sformatf("vec%0d_latency", i), n, 3);
      check_frame($sformatf("vec%0d", i), vec[i].pat, -1, -1);
      h = 0;
      while (busy === 1'b1 && h < 30) begin
        @(negedge clk);
        if (busy === 1'b1) h++;
      end
      chk($sformatf("vec%0d_busy_tail", i), h, 8);
      chk($sformatf("vec%0d_rd_strobes", i), rd_a - rd0, 1);
      skip(2);
    end

    // Back-to-back 0x01 then 0x03
    rd0 = rd_a;
    push_a(8'h01);
    push_a(8'h03);
    wait_start(20, n);
    s1 = cyc;
    check_frame("b2b_0", vec[1].pat, -1, -1);
    wait_start(100, n);
    s2 = cyc;
    chk("b2b_gap", s2 - s1, 59);
    check_frame("b2b_1", vec[2].pat, -1, -1);
    wait_idle("b2b");
    chk("b2b_rd_strobes", rd_a - rd0, 2);

    // Break request and non-empty FIFO in the same IDLE cycle
    rd0 = rd_a;
    push_a(8'hA5);
    break_req = 1'b1;
    skip(1);
    break_req = 1'b0;
    l = 0;
    while (tx === 1'b0 && l < 200) begin
      l++;
      @(negedge clk);
    end
    chk("brk_low_len", l, 96);
    h = 0; bd_pos = -1; bd_rd = -1; busy_idle = -1;
    while (tx === 1'b1 && h < 40) begin
      if (break_done) begin
        bd_pos = h;
        bd_rd = rd_a - rd0;
      end
      if (h == 8) busy_idle = busy;
      h++;
      @(negedge clk);
    end
    chk("brk_high_len", h, 11);
    chk("brk_done_pos", bd_pos, 7);
    chk("brk_no_pop_before_done", bd_rd, 0);
    chk("brk_idle_busy", busy_idle, 0);
    check_frame("brk_then_A5", vec[3].pat, -1, -1);
    wait_idle("brk_prio");

    // Break at DATA bit 3, enable dropped at PARITY
    push_a(8'hFF);
    push_a(8'h55);
    wait_start(20, n);
    chk("mid_latency", n, 3);
    check_frame("mid_FF", vec[4].pat, 17, 37);
    h = 0;
    @(negedge clk);
    while (tx === 1'b1 && h < 30) begin
      h++;
      @(negedge clk);
    end
    chk("mid_gap_to_break", h, 9);
    l = 0;
    while (tx === 1'b0 && l < 200) begin
      l++;
      @(negedge clk);
    end
    chk("mid_break_len", l, 96);
    rd0 = rd_a;
    bd_cnt = 0; tx0_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (break_done) bd_cnt++;
      if (tx === 1'b0) tx0_cnt++;
      @(negedge clk);
    end
    chk("mid_break_done_cnt", bd_cnt, 1);
    chk("mid_no_pop_disabled", rd_a - rd0, 0);
    chk("mid_tx_idle_disabled", tx0_cnt, 0);
    chk("mid_busy_disabled", busy, 0);
    enable = 1'b1;
    wait_start(20, n);
    chk("mid_resume_latency", n, 3);
    check_frame("mid_55", vec[0].pat, -1, -1);
    wait_idle("mid");

    // Reset during DATA bit 5 with a pending break
    push_a(8'h3C);
    wait_start(20, n);
    skip(17);
    break_req = 1'b1;
    skip(1);
    break_req = 1'b0;
    skip(7);
    rst_n = 1'b0;
    skip(1);
    rst_n = 1'b1;
    chk("rstmid_tx", tx, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_brk_pend", int'(dut.brk_pend_q), 0);
    tx0_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (tx === 1'b0) tx0_cnt++;
      if (busy === 1'b1) busy_cnt++;
    end
    chk("rstmid_quiet_tx", tx0_cnt, 0);
    chk("rstmid_quiet_busy", busy_cnt, 0);
    push_a(8'h80);
    wait_start(20, n);
    chk("rstmid_next_latency", n, 3);
    check_frame("rstmid_80", vec[5].pat, -1, -1);
    wait_idle("rstmid");

    // No-guard instance: two queued bytes
    push_b(8'h01);
    push_b(8'h03);
    n = 0;
    while (tx_b !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ng_latency", n, 3);
    s1 = cyc;
    skip(48);
    chk("ng_idle_tx", tx_b, 1);
    chk("ng_idle_busy", busy_b, 0);
    n = 0;
    while (tx_b !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    s2 = cyc;
    chk("ng_gap", s2 - s1, 51);
    skip(60);
    chk("ng_rd_strobes", rd_b, 2);
    chk("ng_busy_end", busy_b, 0);

    // Global FIFO sanity
    chk("no_rd_when_empty", bad_rd, 0);
    chk("fifo_a_drained", rd_a, wr_a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updi_tx_sequencer.md
# updi_tx_sequencer

Drains the transmit byte FIFO and serialises each byte as a UPDI UART frame on the single-wire PDI line: 1 start bit, 8 data bits LSB first, even parity, 2 stop bits. It also generates UPDI BREAK sequences on request. The block sits between the TX `fifo` instance and the line driver. It owns the FIFO read port and is the only block that sequences FIFO reads.

## Interface
- `CLK_DIV`, default 16: clk cycles per bit time; must be ≥ 2.
- `GUARD_BITS`, default 2: idle-high bit times inserted after every frame; 0 means no guard.
- `BREAK_BITS`, default 24: low bit times in a BREAK.

- `clk`  in  1  single clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `enable`  in  1  permits starting new frames.
- `fifo_data`  in  8  FIFO `out`; valid the cycle after a read strobe.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  one-cycle read strobe to the FIFO.
- `break_req`  in  1  single-cycle request for a BREAK.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high whenever the state is not IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of a byte frame.
- `break_done`  out  1  one-cycle pulse at the end of a BREAK sequence.

## Operation
- States: IDLE, POP, LOAD, START, DATA, PARITY, STOP, GUARD, BREAK, BRK_HI.
- `break_req` sets a `brk_pend` flag. The flag clears when BREAK is entered.
- IDLE transitions:
  - `brk_pend`=1 → BREAK. This has priority over FIFO data.
  - Otherwise, `enable`=1 and `fifo_empty`=0 → POP.
  - Otherwise, stay in IDLE.
- POP: `fifo_rd_en`=1 for exactly this cycle, then → LOAD.
- LOAD: capture `fifo_data` into the shift register and clear the parity accumulator, then → START.
- START: `tx`=0.
- DATA: 8 bits, LSB first. Parity = XOR of the data bits (even parity).
- PARITY: `tx` = parity bit.
- STOP: `tx`=1 for 2 bit times. `frame_done` pulses on the last cycle of the second stop bit.
- After STOP: → GUARD if `GUARD_BITS`>0, else → IDLE.
- GUARD: `tx`=1 for `GUARD_BITS` bit times, then → IDLE.
- BREAK: `tx`=0 for `BREAK_BITS` bit times, then → BRK_HI.
- BRK_HI: `tx`=1 for 2 bit times. `break_done` pulses on the last cycle, then → IDLE.
- `enable` falling mid-frame: the current frame completes in full and no new POP is issued.
- `break_req` arriving mid-frame or mid-BREAK: latched and served at the next IDLE. Only one pending break is held; further requests merge into it.
- The block never issues `fifo_rd_en` while `fifo_empty`=1.
- Reset, from any state, takes effect at the next edge:
  - State → IDLE.
  - `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0, `break_done`=0.
  - `brk_pend` cleared and counters cleared.
  - A partially sent byte is dropped, not re-sent.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- Start-up latency: IDLE samples the start condition at cycle t. POP is in cycle t+1, LOAD in t+2, and START (first `tx`=0 cycle) in t+3.
- Every bit time is exactly `CLK_DIV` cycles, counted by a divider that restarts at each state entry.
- Frame length: 12·`CLK_DIV` cycles. Back-to-back frame period: (12+`GUARD_BITS`)·`CLK_DIV` + 3 cycles, counting IDLE, POP and LOAD.
- BREAK sequence length: (`BREAK_BITS`+2)·`CLK_DIV` cycles, plus 1 IDLE cycle.
- `break_req` and a non-empty FIFO present in the same IDLE cycle: the BREAK goes first, and the FIFO byte follows after `break_done`.

## Structure
- `updi_pkg` holds:
  - the `tx_state_t` enum;
  - the constants `UPDI_DATA_BITS`=8, `UPDI_STOP_BITS`=2 and `BRK_HI_BITS`=2.
- One sub-module, `baud_tick`:
  - parameter `CLK_DIV`;
  - inputs `clk`, `rst_n`, `restart`;
  - output `tick`, pulsing on the last cycle of each bit time.
- The bit counter, shift register and state machine are all in `updi_tx_sequencer`.

## Test plan
Unless stated otherwise, all scenarios use `CLK_DIV`=4 and `GUARD_BITS`=2.

- **Single byte 0x55.**
  - Stimulus: FIFO holds 0x55, `enable`=1.
  - Required: one `fifo_rd_en` pulse. `tx` per bit time = 0,1,0,1,0,1,0,1,0,0,1,1 (parity 0). `frame_done` pulses at cycle 48 of the frame. `busy` stays high 8 cycles longer, then falls.
- **Parity and back-to-back frames.**
  - Stimulus: FIFO holds 0x01 then 0x03.
  - Required: parity bits 1 then 0. Gap between the two frames' start bits = 14·4+3 = 59 cycles. Exactly 2 read strobes. No strobe once `fifo_empty`=1.
- **Break priority.**
  - Stimulus: `break_req` pulse and a non-empty FIFO (0xA5) in the same cycle, `BREAK_BITS`=24.
  - Required: `tx` low for 96 cycles, then high for 8 cycles with `break_done`. Only then does the 0xA5 frame start.
- **Break during a frame, plus enable drop.**
  - Stimulus: `break_req` at DATA bit 3. Separately, `enable`=0 at the PARITY bit.
  - Required: the frame completes intact, then the BREAK is sent. After that, no POP occurs while `enable`=0.
- **Reset mid-frame.**
  - Stimulus: `rst_n`=0 for 1 cycle during DATA bit 5, with a pending break.
  - Required: next cycle `tx`=1, `busy`=0, `brk_pend`=0. Nothing is transmitted until the next FIFO byte, which starts cleanly with START.
- **Guard disabled.**
  - Stimulus: `GUARD_BITS`=0, two bytes queued.
  - Required: start bits are 12·4+3 = 51 cycles apart.
